// File: rtl/serial_rx.sv
// 8N1 UART receiver with a first-word-fall-through receive buffer and valid/ready output.
// Define SERIAL_RX_FIFO_EN for the FIFO_DEPTH-entry buffer; otherwise a single holding register is used.
module serial_rx #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_char,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overrun,
  output logic       o_frame_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_TC  = TW'(CLKS_PER_BIT - 1);

  // state     | meaning
  // IDLE      | line high, waiting for a start edge
  // START     | timing to mid start bit, rejects glitches
  // DATA      | sampling 8 data bits LSB first
  // STOP      | sampling the stop bit
  // WAIT_HIGH | framing error or break, waiting for line to return high
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serial_rx: FIFO_DEPTH must be a power of 2 in 2..64");
  end

  logic [1:0]    r_sync;
  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_armed;
  logic          r_frame_err;
  logic          r_overrun;
  logic          w_rx_s;
  logic          w_push;
  logic          w_pop;

  assign w_rx_s = r_sync[1];
  assign w_push = (r_state == ST_STOP) && (r_timer == BIT_TC) && w_rx_s;
  assign w_pop  = o_valid & i_ready;

  // r_armed ensures a line still low after reset is not mistaken for a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= 2'b11;
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_armed     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_frame_err <= 1'b0;
      if (w_rx_s) r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s && r_armed) begin
            r_state <= ST_START;
            r_timer <= '0;
          end
        end
        ST_START: begin
          if (r_timer == HALF_TC) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_DATA: begin
          if (r_timer == BIT_TC) begin
            r_timer <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              r_state   <= ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_STOP: begin
          if (r_timer == BIT_TC) begin
            r_timer <= '0;
            if (w_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_empty;
  logic        w_full;
  logic        w_write;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  // A pop frees the slot on the same edge, so a full buffer still accepts the push.
  assign w_write = w_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_write) r_mem[r_wr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_write) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)   r_rd <= r_rd + (AW+1)'(1);
    end
  end

  assign o_valid = !w_empty;
  assign o_char  = o_valid ? r_mem[r_rd[AW-1:0]] : 8'h00;
`else
  logic [7:0] r_hold;
  logic       r_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold    <= 8'h00;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_push) begin
        if (!r_full || w_pop) begin
          r_hold <= r_shift;
          r_full <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_pop) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_valid = r_full;
  assign o_char  = r_full ? r_hold : 8'h00;
`endif

  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, meaning the i_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division; 104 at defaults).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning receive buffer entries; power of 2, 2..64.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_rx, input, 1, asynchronous serial line, 8N1, idle high.
REQ-007 SHALL have port o_char, output, 8, the received byte at the buffer head; it feeds the terminal controller's character input.
REQ-008 SHALL have port o_valid, output, 1, high while o_char holds an unconsumed byte.
REQ-009 SHALL have port i_ready, input, 1, consumer ready; a byte transfers on a cycle where o_valid & i_ready.
REQ-010 SHALL have port o_overrun, output, 1, one-cycle pulse when a good byte is dropped because the buffer is full.
REQ-011 SHALL have port o_frame_err, output, 1, one-cycle pulse when a stop bit samples low.

Function
REQ-012 SHALL pass i_rx through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-013 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 SHALL move IDLE -> START when the synchronized line is low, clearing the bit-timer.
REQ-015 SHALL sample in START at timer = CLKS_PER_BIT/2 - 1: high -> IDLE (glitch rejected, no output); low -> DATA with the timer cleared.
REQ-016 SHALL sample in DATA every CLKS_PER_BIT cycles and shift the bit in LSB-first; after the 8th bit the state SHALL move to STOP.
REQ-017 SHALL sample in STOP after CLKS_PER_BIT cycles: high -> push the byte and move to IDLE; low -> pulse o_frame_err, discard the byte and move to WAIT_HIGH.
REQ-018 SHALL stay in WAIT_HIGH until the synchronized line is high, then move to IDLE; this covers break conditions.
REQ-019 SHALL register the push so that o_valid rises on the cycle after the stop-bit sample when the buffer was empty.
REQ-020 SHALL present the buffer as first-word fall-through: o_char equals the oldest entry while o_valid is high.
REQ-021 SHALL hold o_char and o_valid stable while o_valid is high and i_ready is low.
REQ-022 SHALL, on a push when full with no pop in the same cycle, drop the new byte, pulse o_overrun and leave the stored contents untouched.
REQ-023 SHALL, on a push and a pop in the same cycle, accept both regardless of occupancy, including when full (no overrun).
REQ-024 SHALL wrap the read/write pointers modulo FIFO_DEPTH, using an extra occupancy bit to distinguish full from empty.
REQ-025 SHALL keep receiving, with no lost bit timing, while the consumer stalls, for example during a scroll or clear.

Reset
REQ-026 SHALL, while i_rst is high, set state IDLE, the timer and bit count to 0, both synchronizer flops to 1, the buffer to empty, and o_valid, o_overrun and o_frame_err to 0.
REQ-027 SHALL reset o_char to 8'h00.
REQ-028 SHALL abandon a byte in progress when reset is asserted mid-frame and never output it; reception restarts at the next falling edge after release.

Configuration
REQ-029 SHALL, with macro SERIAL_RX_FIFO_EN defined, implement the FIFO_DEPTH-entry buffer described above.
REQ-030 SHALL, without SERIAL_RX_FIFO_EN, replace the buffer with a single holding register (effective depth 1), with the same valid/ready, overrun and simultaneous push/pop rules, and ignore FIFO_DEPTH.

Verification
REQ-031 SHALL cover: byte 0x41 sent at 115200 with i_ready=1 -> o_valid high for 1 cycle with o_char=0x41, about 990 cycles after the start edge.
REQ-032 SHALL cover: i_rx low for 20 cycles, then high -> no o_valid, no o_frame_err, state back to IDLE.
REQ-033 SHALL cover: 0x55 sent with the stop bit held low for 300 cycles -> one o_frame_err pulse, no o_valid; a following 0x66 is received correctly.
REQ-034 SHALL cover: 17 bytes 0x00..0x10 with i_ready=0 and the macro defined -> one o_overrun pulse on the 17th; raising i_ready then yields 0x00..0x0F in order, then o_valid low.
REQ-035 SHALL cover: buffer full, with a pop on the exact cycle of a push of 0x7E -> no overrun, and 0x7E is the last byte drained.
REQ-036 SHALL cover: i_rst pulsed during bit 4 of 0xA5, then 0x3C sent -> only 0x3C appears.
